// File: rtl/sram_rw_port_ctrl_if.sv
// Client-side channels of the SRAM port controller: write request, read request
// and read response, each with a valid/ready handshake.
interface sram_rw_port_ctrl_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 174,
    parameter int MASK_W = 6
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [MASK_W-1:0] wr_mask;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, rsp_ready,
        input  wr_ready, rd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, rsp_ready,
        output wr_ready, rd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sram_rw_port_ctrl.sv
// Arbitrates client write/read channels onto a single-port masked-write SRAM,
// zero-fills the array after reset and buffers read data in a 2-entry FIFO.
module sram_rw_port_ctrl #(
    parameter int ADDR_W  = 13,
    parameter int DEPTH   = 8192,
    parameter int DATA_W  = 174,
    parameter int MASK_W  = 6,
    parameter bit INIT_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    sram_rw_port_ctrl_if.slave bus,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] cnt_r;
    logic              prio_r;       // 0 = write preferred, 1 = read preferred
    logic              inflight_r;
    logic              init_done_r;
    logic [DATA_W-1:0] fifo_mem_r [2];
    logic              fifo_rd_ptr_r;
    logic              fifo_wr_ptr_r;
    logic [1:0]        fifo_cnt_r;

    logic              pop_s;
    logic [2:0]        credit_s;
    logic              rd_allow_s;
    logic              run_s;
    logic              wr_elig_s;
    logic              rd_elig_s;
    logic              gnt_wr_s;
    logic              gnt_rd_s;

    // Gating by reset_n keeps the port idle while reset is held, not just after the edge.
    assign pop_s      = (fifo_cnt_r != 2'd0) & bus.rsp_ready;
    assign credit_s   = {1'b0, fifo_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign rd_allow_s = (credit_s < 3'd2);
    assign run_s      = reset_n & (state_r == ST_RUN);
    assign wr_elig_s  = run_s & bus.wr_valid;
    assign rd_elig_s  = run_s & bus.rd_valid & rd_allow_s;
    assign gnt_wr_s   = wr_elig_s & (~rd_elig_s | ~prio_r);
    assign gnt_rd_s   = rd_elig_s & (~wr_elig_s | prio_r);

    assign bus.wr_ready  = gnt_wr_s;
    assign bus.rd_ready  = gnt_rd_s;
    assign bus.rsp_valid = (fifo_cnt_r != 2'd0);
    assign bus.rsp_data  = fifo_mem_r[fifo_rd_ptr_r];
    assign init_done     = init_done_r;

    // SRAM command mux: init sweep, granted write, granted read, or idle.
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = {ADDR_W{1'b0}};
        sram_wmask = {MASK_W{1'b0}};
        sram_wdata = {DATA_W{1'b0}};
        if (reset_n && (state_r == ST_INIT)) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = cnt_r;
            sram_wmask = {MASK_W{1'b1}};
            sram_wdata = {DATA_W{1'b0}};
        end else if (gnt_wr_s) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = bus.wr_addr;
            sram_wmask = bus.wr_mask;
            sram_wdata = bus.wr_data;
        end else if (gnt_rd_s) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b0;
            sram_addr  = bus.rd_addr;
        end else begin
            sram_en    = 1'b0;
        end
    end

    // Control FSM: init sweep counter, round-robin priority and read in-flight flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r     <= INIT_EN ? ST_INIT : ST_RUN;
            cnt_r       <= {ADDR_W{1'b0}};
            prio_r      <= 1'b0;
            inflight_r  <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            inflight_r <= gnt_rd_s;
            case (state_r)
                ST_INIT: begin
                    cnt_r <= cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (cnt_r == ADDR_W'(DEPTH - 1)) begin
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    init_done_r <= 1'b1;
                    // The priority only rotates when both sides actually competed.
                    if (wr_elig_s && rd_elig_s) begin
                        prio_r <= ~prio_r;
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

    // Response FIFO: push the SRAM read data one cycle after issue, pop on handshake.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fifo_mem_r[0] <= {DATA_W{1'b0}};
            fifo_mem_r[1] <= {DATA_W{1'b0}};
            fifo_rd_ptr_r <= 1'b0;
            fifo_wr_ptr_r <= 1'b0;
            fifo_cnt_r    <= 2'd0;
        end else begin
            if (inflight_r) begin
                fifo_mem_r[fifo_wr_ptr_r] <= sram_rdata;
                fifo_wr_ptr_r             <= ~fifo_wr_ptr_r;
            end
            if (pop_s) begin
                fifo_rd_ptr_r <= ~fifo_rd_ptr_r;
            end
            case ({inflight_r, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Directed bench for sram_rw_port_ctrl with a behavioural 1-cycle-read masked SRAM.
module tb_sram_rw_port_ctrl;
    localparam int ADDR_W = 13;
    localparam int DEPTH  = 8192;
    localparam int DATA_W = 174;
    localparam int MASK_W = 6;
    localparam int LANE_W = 29;

    localparam logic [DATA_W-1:0] MASKED = {{LANE_W{1'b1}}, {LANE_W{1'b1}}, {LANE_W{1'b1}},
                                            {LANE_W{1'b0}}, {LANE_W{1'b1}}, {LANE_W{1'b0}}};
    localparam logic [DATA_W-1:0] P7 = 174'h0123_4567_89AB_CDEF_FEDC_BA98;
    localparam logic [DATA_W-1:0] P9 = 174'h2A_5555_AAAA_1357_9BDF;

    logic              clock;
    logic              reset_n;
    logic              init_done;
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [MASK_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic [DATA_W-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;
    int bad;
    int seen;

    sram_rw_port_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

    sram_rw_port_ctrl #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .MASK_W(MASK_W), .INIT_EN(1'b1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus), .init_done(init_done),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural SRAM: lane-masked write, registered read data.
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int l = 0; l < MASK_W; l++) begin
                    if (sram_wmask[l]) mem[sram_addr][l*LANE_W +: LANE_W] <= sram_wdata[l*LANE_W +: LANE_W];
                end
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic nc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic sweep(output int nbad, output int nseen);
        nbad  = 0;
        nseen = 0;
        for (int i = 0; i < DEPTH; i++) begin
            smp();
            if (!(sram_en === 1'b1 && sram_wmode === 1'b1 && sram_addr === ADDR_W'(i) &&
                  sram_wmask === 6'h3F && sram_wdata === {DATA_W{1'b0}} &&
                  bus.wr_ready === 1'b0 && bus.rd_ready === 1'b0 && init_done === 1'b0))
                nbad++;
            if (bus.rsp_valid !== 1'b0) nseen++;
            nc();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_addr = 13'h1FFF; bus.wr_data = {DATA_W{1'b0}}; bus.wr_mask = 6'h00;
        bus.rd_valid = 1'b1; bus.rd_addr = 13'd5; bus.rsp_ready = 1'b1;
        nc(); nc(); smp();
        check("rst_wr_ready", bus.wr_ready, 1'b0);
        check("rst_rd_ready", bus.rd_ready, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_sram_en", sram_en, 1'b0);

        // Power-on sweep with both request channels asserted.
        nc(); reset_n = 1'b1;
        sweep(bad, seen);
        check("init_sweep1", bad, 0);
        smp();
        check("init_done_rise", init_done, 1'b1);
        check("first_grant_wr", {bus.wr_ready, bus.rd_ready}, 2'b10);
        check("mask0_issued", {sram_en, sram_wmode, sram_wmask}, {1'b1, 1'b1, 6'h00});

        nc(); bus.wr_valid = 1'b0; bus.rd_valid = 1'b1; bus.rd_addr = 13'd5; smp();
        check("rd5_accept", bus.rd_ready, 1'b1);
        check("rd5_issue", {sram_en, sram_wmode, sram_addr}, {1'b1, 1'b0, 13'd5});
        nc(); bus.rd_valid = 1'b0; smp();
        check("rd5_lat1", bus.rsp_valid, 1'b0);
        nc(); smp();
        check("rd5_lat2", bus.rsp_valid, 1'b1);
        check("rd5_data", bus.rsp_data, {DATA_W{1'b0}});
        nc(); smp();
        check("rd5_popped", bus.rsp_valid, 1'b0);

        // Distinct patterns, then the masked overwrite and an immediate read-back.
        nc(); bus.wr_valid = 1'b1; bus.wr_addr = 13'd7; bus.wr_data = P7; bus.wr_mask = 6'h3F; smp();
        check("wr7", bus.wr_ready, 1'b1);
        nc(); bus.wr_addr = 13'd9; bus.wr_data = P9; smp();
        check("wr9", bus.wr_ready, 1'b1);
        nc(); bus.wr_addr = 13'h100; bus.wr_data = {DATA_W{1'b1}}; smp();
        check("wr100_full", bus.wr_ready, 1'b1);
        nc(); bus.wr_data = {DATA_W{1'b0}}; bus.wr_mask = 6'h05; smp();
        check("wr100_mask", bus.wr_ready, 1'b1);
        check("wr100_pass", {sram_addr, sram_wmask}, {13'h100, 6'h05});
        nc(); bus.wr_valid = 1'b0; bus.rd_valid = 1'b1; bus.rd_addr = 13'h100; smp();
        check("rd100_accept", bus.rd_ready, 1'b1);
        nc(); bus.rd_valid = 1'b0; smp();
        check("rd100_lat1", bus.rsp_valid, 1'b0);
        nc(); smp();
        check("rd100_valid", bus.rsp_valid, 1'b1);
        check("rd100_data", bus.rsp_data, MASKED);

        // Backpressure: two credits, then stall until the client drains.
        nc(); bus.rsp_ready = 1'b0; bus.rd_valid = 1'b1; bus.rd_addr = 13'h100; smp();
        check("bp_a_accept", bus.rd_ready, 1'b1);
        nc(); bus.rd_addr = 13'd5; smp();
        check("bp_b_accept", bus.rd_ready, 1'b1);
        nc(); bus.rd_addr = 13'd7; smp();
        check("bp_c_block", bus.rd_ready, 1'b0);
        nc(); bus.wr_valid = 1'b1; bus.wr_addr = 13'h1FFF; bus.wr_mask = 6'h00; smp();
        check("bp_d_block", bus.rd_ready, 1'b0);
        check("bp_d_wr", bus.wr_ready, 1'b1);
        check("bp_d_hold", {bus.rsp_valid, bus.rsp_data}, {1'b1, MASKED});
        nc(); bus.wr_valid = 1'b0; bus.rsp_ready = 1'b1; smp();
        check("bp_e_accept", bus.rd_ready, 1'b1);
        check("bp_e_data", bus.rsp_data, MASKED);
        nc(); bus.rd_addr = 13'd9; smp();
        check("bp_f_accept", bus.rd_ready, 1'b1);
        check("bp_f_data", {bus.rsp_valid, bus.rsp_data}, {1'b1, {DATA_W{1'b0}}});
        nc(); bus.rd_valid = 1'b0; smp();
        check("bp_g_data", {bus.rsp_valid, bus.rsp_data}, {1'b1, P7});
        nc(); smp();
        check("bp_h_data", {bus.rsp_valid, bus.rsp_data}, {1'b1, P9});
        nc(); smp();
        check("bp_i_empty", bus.rsp_valid, 1'b0);

        // Contention after a fresh reset: strict W,R alternation starting with a write.
        nc(); reset_n = 1'b0;
        nc(); reset_n = 1'b1;
        sweep(bad, seen);
        check("init_sweep2", bad, 0);
        bus.wr_valid = 1'b1; bus.rd_valid = 1'b1; bus.rd_addr = 13'd7;
        for (int k = 0; k < 6; k++) begin
            smp();
            check($sformatf("contend_%0d", k), {bus.wr_ready, bus.rd_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
            nc();
        end
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
        nc(); nc(); nc(); smp();
        check("contend_drained", bus.rsp_valid, 1'b0);

        // Reset with one read in flight and one response buffered.
        nc(); bus.rsp_ready = 1'b0; bus.rd_valid = 1'b1; bus.rd_addr = 13'd7; smp();
        check("mid_rd_x", bus.rd_ready, 1'b1);
        nc(); bus.rd_addr = 13'd9; smp();
        check("mid_rd_y", bus.rd_ready, 1'b1);
        nc(); bus.rd_valid = 1'b0; reset_n = 1'b0; smp();
        check("mid_rst_en", sram_en, 1'b0);
        nc(); reset_n = 1'b1; bus.rsp_ready = 1'b1;
        sweep(bad, seen);
        check("init_sweep3", bad, 0);
        check("mid_no_stale", seen, 0);
        smp();
        check("mid_init_done", init_done, 1'b1);
        check("mid_rsp_idle", bus.rsp_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
